eth_mac_filter: RTL
===================

ETH_MAC_FILTER -- requirements
Module: ethmacfilt

Interface
REQ-001 clk  input  1  system clock; all registers update on falling edge, same domain as the frame receiver.
REQ-002 clr  input  1  reset, asynchronous, active-high.
REQ-003 mac_data  input  48  received destination MAC; [7:0] = first received byte, [47:40] = sixth.
REQ-004 mac_rdy  input  1  level; high while mac_data is complete and stable, low between frames.
REQ-005 prom  input  1  promiscuous mode: accept every frame.
REQ-006 allmc  input  1  accept every multicast frame (mac_data[0] = 1).
REQ-007 tbl_we  input  1  one-clock strobe: write tbl_data into entry tbl_addr and mark it valid.
REQ-008 tbl_addr  input  4  table entry index, 0..13 legal; 14..15 writes are ignored.
REQ-009 tbl_data  input  48  address to store, same byte order as mac_data.
REQ-010 tbl_clr  input  1  one-clock strobe: clear all 14 valid bits.
REQ-011 cmp_done  output  1  comparison finished; held high until mac_rdy falls.
REQ-012 cmp_res  output  1  1 = accept frame, 0 = reject; meaningful only while cmp_done = 1.
REQ-013 busy  output  1  high in LATCH and SCAN states.

Function
REQ-014 Table SHALL hold 14 entries of 48-bit address plus one valid bit each.
REQ-015 FSM states SHALL be IDLE, LATCH, SCAN, DONE.
REQ-016 IDLE: mac_rdy = 1 SHALL load mac_data into internal register and go to LATCH next clock.
REQ-017 LATCH: prom = 1, or (allmc = 1 and latched bit 0 = 1), or broadcast per REQ-029 SHALL go to DONE with cmp_res = 1; otherwise go to SCAN with index 0.
REQ-018 SCAN: SHALL compare one entry per clock; valid entry equal to latched address goes to DONE with cmp_res = 1.
REQ-019 SCAN: no match at index 13 SHALL go to DONE with cmp_res = 0; index SHALL never exceed 13.
REQ-020 Worst-case latency mac_rdy rise to cmp_done = 1 SHALL be 16 clocks; fast path 2 clocks.
REQ-021 DONE: cmp_done = 1, cmp_res stable; mac_rdy = 0 SHALL return to IDLE with cmp_done = 0, cmp_res = 0 next clock.
REQ-022 mac_rdy falling during LATCH or SCAN SHALL abort to IDLE with cmp_done = 0.
REQ-023 mac_data changes after LATCH SHALL not affect the result.
REQ-024 tbl_we or tbl_clr while busy = 1 SHALL be dropped; no table change.
REQ-025 tbl_we and tbl_clr in the same clock (busy = 0): tbl_clr wins, written entry not marked valid.
REQ-026 Table writes in IDLE or DONE SHALL take effect on the next clock edge.
REQ-027 prom and allmc SHALL be sampled in LATCH only.

Reset
REQ-028 clr = 1 SHALL force IDLE, cmp_done = 0, cmp_res = 0, busy = 0, all valid bits 0, scan index 0, at any time including mid-scan; entry address data not reset.

Configuration
REQ-029 Macro ETHMACFILT_BCAST_EN defined: address FF:FF:FF:FF:FF:FF SHALL be accepted in LATCH regardless of table; undefined: broadcast accepted only via prom, allmc (bit 0 set) or a matching table entry.

Verification
REQ-030 Write entry 3 = 08:00:2B:12:34:56, frame with same address -> cmp_done after 6 clocks (LATCH + SCAN 0..3 + DONE), cmp_res = 1.
REQ-031 Empty table, unicast 02:00:00:00:00:01, prom = 0 -> cmp_done at clock 16, cmp_res = 0.
REQ-032 prom = 1, any address -> cmp_done at clock 2, cmp_res = 1; allmc = 1 with 01:00:5E:00:00:01 -> accept at clock 2.
REQ-033 tbl_we pulsed during SCAN -> entry unchanged, next frame to that address rejected; tbl_we + tbl_clr same clock -> all invalid.
REQ-034 clr asserted mid-SCAN -> outputs 0, valid bits 0 next edge; mac_rdy dropped mid-SCAN -> IDLE, no cmp_done.
REQ-035 Broadcast frame, empty table, prom = allmc = 0 -> cmp_res = 1 at clock 2 with ETHMACFILT_BCAST_EN, cmp_res = 0 at clock 16 without.

Source files
------------

// File: rtl/eth_mac_filter.sv
// Destination-MAC acceptance filter: 14-entry address table scanned one entry per clock.
// Optional macro ETHMACFILT_BCAST_EN accepts FF:FF:FF:FF:FF:FF on the fast path.
module eth_mac_filter (
  input  logic        clk,
  input  logic        clr,
  input  logic [47:0] mac_data,
  input  logic        mac_rdy,
  input  logic        prom,
  input  logic        allmc,
  input  logic        tbl_we,
  input  logic [3:0]  tbl_addr,
  input  logic [47:0] tbl_data,
  input  logic        tbl_clr,
  output logic        cmp_done,
  output logic        cmp_res,
  output logic        busy
);

  localparam int unsigned MAC_W    = 48;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned N_ENT    = 14;
  localparam int unsigned LAST_IDX = N_ENT - 1;

  typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;

  state_t             state, state_nx;
  logic [MAC_W-1:0]   mac_q, mac_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               done_nx, res_nx, busy_nx;
  logic [MAC_W-1:0]   tbl_mem [N_ENT];
  logic [N_ENT-1:0]   tbl_vld;
  logic               bcast_hit, fast_hit, ent_hit, tbl_wr_ok, tbl_addr_ok;

`ifdef ETHMACFILT_BCAST_EN
  assign bcast_hit = &mac_q;
`else
  assign bcast_hit = 1'b0;
`endif

  assign fast_hit    = prom | (allmc & mac_q[0]) | bcast_hit;
  assign ent_hit     = tbl_vld[idx] && (tbl_mem[idx] == mac_q);
  assign tbl_wr_ok   = (state == IDLE) || (state == DONE);
  assign tbl_addr_ok = tbl_addr < IDX_W'(N_ENT);

  // Next-state and next-output logic
  always_comb begin
    state_nx = state;
    mac_nx   = mac_q;
    idx_nx   = idx;
    done_nx  = 1'b0;
    res_nx   = 1'b0;
    busy_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (mac_rdy) begin
          mac_nx   = mac_data;
          state_nx = LATCH;
          busy_nx  = 1'b1;
        end
      end
      LATCH: begin
        if (!mac_rdy) begin
          state_nx = IDLE;
        end else if (fast_hit) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          res_nx   = 1'b1;
        end else begin
          state_nx = SCAN;
          idx_nx   = '0;
          busy_nx  = 1'b1;
        end
      end
      SCAN: begin
        if (!mac_rdy) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else if (ent_hit || (idx == IDX_W'(LAST_IDX))) begin
          state_nx = DONE;
          idx_nx   = '0;
          done_nx  = 1'b1;
          res_nx   = ent_hit;
        end else begin
          idx_nx   = IDX_W'(idx + 1'b1);
          busy_nx  = 1'b1;
        end
      end
      DONE: begin
        if (!mac_rdy) begin
          state_nx = IDLE;
        end else begin
          done_nx = 1'b1;
          res_nx  = cmp_res;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      mac_q    <= '0;
      idx      <= '0;
      cmp_done <= 1'b0;
      cmp_res  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      mac_q    <= mac_nx;
      idx      <= idx_nx;
      cmp_done <= done_nx;
      cmp_res  <= res_nx;
      busy     <= busy_nx;
    end
  end

  // Valid bits: table updates only while not busy; clear beats write
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      tbl_vld <= '0;
    end else if (tbl_wr_ok && tbl_clr) begin
      tbl_vld <= '0;
    end else if (tbl_wr_ok && tbl_we && tbl_addr_ok) begin
      tbl_vld[tbl_addr] <= 1'b1;
    end
  end

  // Address storage is not reset
  always_ff @(negedge clk) begin
    if (tbl_wr_ok && tbl_we && tbl_addr_ok && !tbl_clr) begin
      tbl_mem[tbl_addr] <= tbl_data;
    end
  end

endmodule
